// File: rtl/sar_compare_pkg.sv
// rtl/sar_compare_pkg.sv - shared types and flag encodings for the SAR compare search
package sar_compare_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } sar_state_t;

  // Flag patterns are ordered {eq, geq, lt}
  localparam logic [2:0] FLAG_EQ = 3'b110;
  localparam logic [2:0] FLAG_GT = 3'b010;
  localparam logic [2:0] FLAG_LT = 3'b001;

  function automatic logic flags_legal(input logic [2:0] flags);
    return (flags == FLAG_EQ) || (flags == FLAG_GT) || (flags == FLAG_LT);
  endfunction

endpackage

// File: rtl/sar_compare_search_if.sv
// rtl/sar_compare_search_if.sv - control plus comparator bundle for the SAR search
interface sar_compare_search_if #(
  parameter int WIDTH   = 2,
  parameter int STEPS_W = $clog2(WIDTH + 1)
);
  logic               start;
  logic               cmp_eq;
  logic               cmp_geq;
  logic               cmp_lt;
  logic [WIDTH-1:0]   probe;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  logic [STEPS_W-1:0] steps;
  logic               err;

  // master is the search controller; slave is the requester plus comparator side
  modport master (
    input  start, cmp_eq, cmp_geq, cmp_lt,
    output probe, busy, done, result, steps, err
  );

  modport slave (
    output start, cmp_eq, cmp_geq, cmp_lt,
    input  probe, busy, done, result, steps, err
  );
endinterface

// File: rtl/sar_compare_search.sv
// rtl/sar_compare_search.sv - binary search of a hidden operand via an external comparator
module sar_compare_search
  import sar_compare_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int STEPS_W = $clog2(WIDTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  sar_compare_search_if.master bus
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] TOP_BIT = WIDTH'(1) << (WIDTH - 1);

  sar_state_t       state;
  logic [IDX_W-1:0] bitIdx;
  logic [2:0]       flags;
  logic [WIDTH-1:0] resolvedProbe;
  logic [WIDTH-1:0] nextBit;

  assign flags   = {bus.cmp_eq, bus.cmp_geq, bus.cmp_lt};
  assign nextBit = WIDTH'(1) << (bitIdx - 1'b1);

  // Probe with the bit under test kept (A above) or dropped (A below)
  always_comb begin
    resolvedProbe = bus.probe;
    if (flags == FLAG_LT) begin
      resolvedProbe[bitIdx] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bitIdx     <= '0;
      bus.probe  <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.steps  <= '0;
      bus.err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            state      <= SEARCH;
            bus.busy   <= 1'b1;
            bus.probe  <= TOP_BIT;
            bitIdx     <= IDX_W'(WIDTH - 1);
            bus.steps  <= '0;
            bus.err    <= 1'b0;
            bus.result <= '0;
          end
        end
        SEARCH: begin
          bus.steps <= bus.steps + STEPS_W'(1);
          if (!flags_legal(flags)) begin
            bus.err    <= 1'b1;
            bus.result <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            state      <= DONE;
          end else if (flags == FLAG_EQ) begin
            bus.result <= bus.probe;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            state      <= DONE;
          end else if (bitIdx == '0) begin
            bus.result <= resolvedProbe;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            state      <= DONE;
          end else begin
            bus.probe <= resolvedProbe | nextBit;
            bitIdx    <= bitIdx - 1'b1;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_compare_search.sv
// tb/tb_sar_compare_search.sv - self-checking bench for sar_compare_search at WIDTH 4 and 2
module tb_sar_compare_search;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sar_compare_search_if #(.WIDTH(4)) b4();
  sar_compare_search_if #(.WIDTH(2)) b2();

  sar_compare_search #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  sar_compare_search #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  logic       start4 = 1'b0, start2 = 1'b0;
  logic [3:0] hiddenA4 = '0;
  logic [1:0] hiddenA2 = '0;
  logic       ovr4 = 1'b0, ovr2 = 1'b0;
  logic [2:0] ovrFlags4 = '0, ovrFlags2 = '0;
  logic [2:0] flags4, flags2;

  // Behavioural comparators with an override hook for illegal flag injection
  always_comb begin
    if (ovr4) flags4 = ovrFlags4;
    else if (hiddenA4 == b4.probe) flags4 = 3'b110;
    else if (hiddenA4 > b4.probe) flags4 = 3'b010;
    else flags4 = 3'b001;
    if (ovr2) flags2 = ovrFlags2;
    else if (hiddenA2 == b2.probe) flags2 = 3'b110;
    else if (hiddenA2 > b2.probe) flags2 = 3'b010;
    else flags2 = 3'b001;
  end

  assign b4.start = start4;
  assign {b4.cmp_eq, b4.cmp_geq, b4.cmp_lt} = flags4;
  assign b2.start = start2;
  assign {b2.cmp_eq, b2.cmp_geq, b2.cmp_lt} = flags2;

  int selW = 4;
  logic [3:0] curProbe, curResult;
  logic [2:0] curSteps;
  logic       curBusy, curDone, curErr;

  always_comb begin
    if (selW == 4) begin
      curProbe = b4.probe;  curResult = b4.result; curSteps = b4.steps;
      curBusy  = b4.busy;   curDone   = b4.done;   curErr   = b4.err;
    end else begin
      curProbe = {2'b00, b2.probe}; curResult = {2'b00, b2.result}; curSteps = {1'b0, b2.steps};
      curBusy  = b2.busy;           curDone   = b2.done;            curErr   = b2.err;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: the j-th probe is A's top j-1 bits followed by a trial 1
  function automatic int modelProbe(input int w, input int a, input int j);
    int sh = w - j;
    return ((a >> (sh + 1)) << (sh + 1)) | (1 << sh);
  endfunction

  // Search stops at A's lowest set bit, or runs all w steps for A=0
  function automatic int modelSteps(input int w, input int a);
    for (int k = 0; k < w; k++) if (a[k]) return w - k;
    return w;
  endfunction

  task automatic setStart(input int w, input logic v);
    if (w == 4) start4 = v; else start2 = v;
  endtask

  task automatic runSearch(input int w, input int a, input int injAt, input logic [2:0] injFlags,
                           output logic [31:0] r, output logic [31:0] s, output logic [31:0] e,
                           output int doneCyc);
    int evals = 0;
    selW = w;
    if (w == 4) hiddenA4 = a[3:0]; else hiddenA2 = a[1:0];
    r = '1; s = '1; e = '1; doneCyc = -1;
    @(posedge clk); #1;
    setStart(w, 1'b1);
    for (int c = 0; c < 12 && doneCyc < 0; c++) begin
      @(negedge clk);
      if (curBusy) begin
        evals++;
        check($sformatf("probe w%0d a%0d eval%0d", w, a, evals), curProbe, modelProbe(w, a, evals));
        if (evals == injAt) begin
          if (w == 4) begin ovr4 = 1'b1; ovrFlags4 = injFlags; end
          else begin ovr2 = 1'b1; ovrFlags2 = injFlags; end
        end
      end
      if (curDone) begin
        doneCyc = c; r = curResult; s = curSteps; e = curErr;
      end
      @(posedge clk); #1;
      ovr4 = 1'b0; ovr2 = 1'b0;
      setStart(w, 1'b0);
    end
    if (doneCyc < 0) check($sformatf("done timeout w%0d a%0d", w, a), 0, 1);
  endtask

  typedef struct {
    int w; int a; int injAt; logic [2:0] inj;
    int expR; int expS; int expE; int expDone;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] r, s, e;
  int dc;

  initial begin
    vecs.push_back('{4, 10, 0, 3'b000, 10, 3, 0, 4});
    vecs.push_back('{4,  0, 0, 3'b000,  0, 4, 0, 5});
    vecs.push_back('{4, 15, 0, 3'b000, 15, 4, 0, 5});
    vecs.push_back('{4,  8, 0, 3'b000,  8, 1, 0, 2});
    vecs.push_back('{4, 10, 2, 3'b111,  0, 2, 1, 3});
    vecs.push_back('{4, 10, 0, 3'b000, 10, 3, 0, 4});
    vecs.push_back('{4,  5, 1, 3'b000,  0, 1, 1, 2});
    vecs.push_back('{2,  0, 0, 3'b000,  0, 2, 0, 3});
    vecs.push_back('{2,  1, 0, 3'b000,  1, 2, 0, 3});
    vecs.push_back('{2,  2, 0, 3'b000,  2, 1, 0, 2});
    vecs.push_back('{2,  3, 0, 3'b000,  3, 2, 0, 3});

    repeat (2) @(posedge clk);
    #1;
    check("reset w4", {b4.probe, b4.busy, b4.done, b4.result, b4.steps, b4.err}, 0);
    check("reset w2", {b2.probe, b2.busy, b2.done, b2.result, b2.steps, b2.err}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      runSearch(vecs[i].w, vecs[i].a, vecs[i].injAt, vecs[i].inj, r, s, e, dc);
      check($sformatf("vec%0d result", i), r, vecs[i].expR);
      check($sformatf("vec%0d steps", i), s, vecs[i].expS);
      check($sformatf("vec%0d err", i), e, vecs[i].expE);
      check($sformatf("vec%0d done cycle", i), dc, vecs[i].expDone);
    end

    // start held high: every acceptance yields exactly one done
    begin
      int dones = 0, rises = 0;
      logic prevBusy = 1'b0;
      selW = 4; hiddenA4 = 4'd10;
      @(posedge clk); #1; start4 = 1'b1;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (b4.done) dones++;
        if (b4.busy && !prevBusy) rises++;
        prevBusy = b4.busy;
        @(posedge clk); #1;
      end
      start4 = 1'b0;
      repeat (6) @(posedge clk);
      check("held start dones", dones, 4);
      check("held start acceptances", rises, 4);
    end

    // start pulses while busy are ignored
    begin
      int dones = 0, busyCyc = 0, doneAt = -1;
      selW = 4; hiddenA4 = 4'd0;
      @(posedge clk); #1;
      for (int c = 0; c < 10; c++) begin
        start4 = (c == 0 || c == 2 || c == 3);
        @(negedge clk);
        if (b4.done) begin dones++; doneAt = c; end
        if (b4.busy) busyCyc++;
        @(posedge clk); #1;
      end
      start4 = 1'b0;
      check("busy-start dones", dones, 1);
      check("busy-start done cycle", doneAt, 5);
      check("busy-start busy cycles", busyCyc, 4);
    end

    // reset in cycle 2 of a search aborts with no done
    begin
      int sawDone = 0;
      selW = 4; hiddenA4 = 4'd0;
      @(posedge clk); #1; start4 = 1'b1;
      @(posedge clk); #1; start4 = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("abort outputs", {b4.probe, b4.busy, b4.done, b4.result, b4.steps, b4.err}, 0);
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (b4.done || b4.busy) sawDone++;
        if (c == 2) begin @(posedge clk); #1; rst_n = 1'b1; end
      end
      check("abort no done", sawDone, 0);
      runSearch(4, 6, 0, 3'b000, r, s, e, dc);
      check("after abort result", r, 6);
      check("after abort steps", s, 3);
      check("after abort done cycle", dc, 4);
    end

    // randomized searches against the closed-form model
    for (int n = 0; n < 40; n++) begin
      int w, a, injAt, expS, expR, expE;
      logic [2:0] illegal [5];
      illegal = '{3'b000, 3'b011, 3'b100, 3'b101, 3'b111};
      w = ($urandom_range(0, 1) == 1) ? 4 : 2;
      a = $urandom_range(0, (1 << w) - 1);
      injAt = ($urandom_range(0, 2) == 0) ? $urandom_range(1, w) : 0;
      expS = modelSteps(w, a);
      expR = a; expE = 0;
      if (injAt != 0 && injAt <= expS) begin
        expS = injAt; expR = 0; expE = 1;
      end
      runSearch(w, a, injAt, illegal[$urandom_range(0, 4)], r, s, e, dc);
      check($sformatf("rand%0d result w%0d a%0d", n, w, a), r, expR);
      check($sformatf("rand%0d steps", n), s, expS);
      check($sformatf("rand%0d err", n), e, expE);
      check($sformatf("rand%0d done cycle", n), dc, expS + 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
